// File: rtl/readout_rx_result_pkg.sv
// Shared definitions for the readout RX result collector: FSM encoding, error bits, entry layout.
// Entry width depends on READRX_RESULT_TIMESTAMP_EN.
package readout_rx_result_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_PUSH    = 2'd2
    } state_e;

    localparam int ERR_WIDTH   = 3;
    localparam int ERR_UNEXP   = 0;
    localparam int ERR_OVERLAP = 1;
    localparam int ERR_DUP     = 2;

`ifdef READRX_RESULT_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

    // Entry layout, LSB upward: result, got_mask, timeout_flag, [timestamp]
    function automatic int result_lsb();
        return 0;
    endfunction

    function automatic int got_lsb(input int nq);
        return nq;
    endfunction

    function automatic int flag_bit(input int nq);
        return 2 * nq;
    endfunction

    function automatic int ts_lsb(input int nq);
        return 2 * nq + 1;
    endfunction

    function automatic int entry_width_base(input int nq);
        return 2 * nq + 1;
    endfunction

    function automatic int entry_width_ts(input int nq, input int gw);
        return gw + 2 * nq + 1;
    endfunction

    function automatic int entry_width(input int nq, input int gw);
        return TS_EN ? entry_width_ts(nq, gw) : entry_width_base(nq);
    endfunction

endpackage

// File: rtl/readout_rx_result_fifo.sv
// First-word-fall-through FIFO; rd_data is the head entry whenever empty=0.
// A write while full is accepted only when a read happens in the same cycle.
module readout_rx_result_fifo #(
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 17
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr_q, rd_ptr_q;
    logic                  do_wr, do_rd;

    // Extra MSB on the pointers distinguishes full from empty
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                     (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
    assign count   = wr_ptr_q - rd_ptr_q;
    assign do_rd   = rd_en & ~empty;
    assign do_wr   = wr_en & (~full | do_rd);
    assign rd_data = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_wr) begin
                mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_data;
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/readout_rx_result_collector.sv
// Collects one measurement round of per-qubit RX results into an entry and queues it for the host.
// Optional timestamp field enabled by READRX_RESULT_TIMESTAMP_EN.
module readout_rx_result_collector
    import readout_rx_result_pkg::*;
#(
    parameter int NUM_QUBIT         = 8,
    parameter int GLB_COUNTER_WIDTH = 24,
    parameter int FIFO_DEPTH        = 16,
    parameter int FIFO_ADDR_WIDTH   = 4,
    parameter int TIMEOUT_WIDTH     = 16
) (
    input  logic                                                 clk,
    input  logic                                                 rst_n,
    input  logic [GLB_COUNTER_WIDTH-1:0]                         glb_counter,
    input  logic                                                 expect_valid,
    input  logic [NUM_QUBIT-1:0]                                 expect_mask,
    input  logic [TIMEOUT_WIDTH-1:0]                             timeout_cycles,
    input  logic [NUM_QUBIT-1:0]                                 valid_meas_result,
    input  logic [NUM_QUBIT-1:0]                                 meas_result,
    output logic                                                 out_valid,
    input  logic                                                 out_ready,
    output logic [entry_width(NUM_QUBIT, GLB_COUNTER_WIDTH)-1:0] out_data,
    output logic [FIFO_ADDR_WIDTH:0]                             fifo_count,
    input  logic                                                 err_clr,
    output logic [ERR_WIDTH-1:0]                                 err_status
);

    localparam int EW      = entry_width(NUM_QUBIT, GLB_COUNTER_WIDTH);
    localparam int RES_LSB = result_lsb();
    localparam int GOT_LSB = got_lsb(NUM_QUBIT);
    localparam int FLAG    = flag_bit(NUM_QUBIT);

    state_e                 state_q, state_d;
    logic [NUM_QUBIT-1:0]   exp_q, exp_d, got_q, got_d, res_q, res_d;
    logic [TIMEOUT_WIDTH-1:0] timer_q, timer_d;
    logic                   flag_q, flag_d;
    logic [ERR_WIDTH-1:0]   err_q, err_set;
    logic [NUM_QUBIT-1:0]   acc, hit_dup, hit_out;
    logic                   start_round, fifo_wr, fifo_full, fifo_empty, pop;
    logic [EW-1:0]          entry;

    assign out_valid  = ~fifo_empty;
    assign pop        = out_valid & out_ready;
    assign err_status = err_q;

    always_comb begin
        state_d     = state_q;
        exp_d       = exp_q;
        got_d       = got_q;
        res_d       = res_q;
        timer_d     = timer_q;
        flag_d      = flag_q;
        err_set     = '0;
        fifo_wr     = 1'b0;
        start_round = 1'b0;
        acc         = valid_meas_result & exp_q & ~got_q;
        hit_dup     = valid_meas_result & exp_q & got_q;
        hit_out     = valid_meas_result & ~exp_q;
        case (state_q)
            ST_IDLE: begin
                err_set[ERR_UNEXP] = |valid_meas_result;
                if (expect_valid && (|expect_mask)) begin
                    start_round = 1'b1;
                    exp_d       = expect_mask;
                    got_d       = '0;
                    res_d       = '0;
                    timer_d     = timeout_cycles;
                    flag_d      = 1'b0;
                    state_d     = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                err_set[ERR_UNEXP]   = |hit_out;
                err_set[ERR_DUP]     = |hit_dup;
                err_set[ERR_OVERLAP] = expect_valid;
                got_d = got_q | acc;
                res_d = (res_q & ~acc) | (meas_result & acc);
                if (timer_q != '0) begin
                    timer_d = timer_q - TIMEOUT_WIDTH'(1);
                end
                // Completion outranks a timer expiring in the same cycle
                if (got_d == exp_q) begin
                    flag_d  = 1'b0;
                    state_d = ST_PUSH;
                end else if (timer_q == TIMEOUT_WIDTH'(1)) begin
                    flag_d  = 1'b1;
                    state_d = ST_PUSH;
                end
            end
            ST_PUSH: begin
                err_set[ERR_UNEXP]   = |valid_meas_result;
                err_set[ERR_OVERLAP] = expect_valid;
                if (!fifo_full || pop) begin
                    fifo_wr = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            exp_q   <= '0;
            got_q   <= '0;
            res_q   <= '0;
            timer_q <= '0;
            flag_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            got_q   <= got_d;
            res_q   <= res_d;
            timer_q <= timer_d;
            flag_q  <= flag_d;
            err_q   <= (err_clr ? '0 : err_q) | err_set;
        end
    end

`ifdef READRX_RESULT_TIMESTAMP_EN
    localparam int TS_LSB = ts_lsb(NUM_QUBIT);
    logic [GLB_COUNTER_WIDTH-1:0] ts_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q <= '0;
        end else if (start_round) begin
            ts_q <= glb_counter;
        end
    end
`else
    logic unused_glb;
    assign unused_glb = ^glb_counter;
`endif

    always_comb begin
        entry                          = '0;
        entry[RES_LSB +: NUM_QUBIT]    = res_q;
        entry[GOT_LSB +: NUM_QUBIT]    = got_q;
        entry[FLAG]                    = flag_q;
`ifdef READRX_RESULT_TIMESTAMP_EN
        entry[TS_LSB +: GLB_COUNTER_WIDTH] = ts_q;
`endif
    end

    readout_rx_result_fifo #(
        .DEPTH      (FIFO_DEPTH),
        .ADDR_WIDTH (FIFO_ADDR_WIDTH),
        .DATA_WIDTH (EW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (fifo_wr),
        .wr_data (entry),
        .rd_en   (out_ready),
        .rd_data (out_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

endmodule

// File: tb/tb_readout_rx_result_collector.sv
// Bench for readout_rx_result_collector: directed cases plus random rounds against a round-level model.
`timescale 1ns/1ps
module tb_readout_rx_result_collector;

    localparam int NQ  = 8;
    localparam int GW  = 24;
    localparam int FAW = 4;
    localparam int TW  = 16;
`ifdef READRX_RESULT_TIMESTAMP_EN
    localparam int EW = GW + 2 * NQ + 1;
`else
    localparam int EW = 2 * NQ + 1;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [GW-1:0]   glb_counter = '0;
    logic            expect_valid = 1'b0;
    logic [NQ-1:0]   expect_mask = '0;
    logic [TW-1:0]   timeout_cycles = '0;
    logic [NQ-1:0]   valid_meas_result = '0;
    logic [NQ-1:0]   meas_result = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [EW-1:0]   out_data;
    logic [FAW:0]    fifo_count;
    logic            err_clr = 1'b0;
    logic [2:0]      err_status;

    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q [$];
    bit rand_ready = 1'b0;

    always #5 clk = ~clk;

    readout_rx_result_collector dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .glb_counter       (glb_counter),
        .expect_valid      (expect_valid),
        .expect_mask       (expect_mask),
        .timeout_cycles    (timeout_cycles),
        .valid_meas_result (valid_meas_result),
        .meas_result       (meas_result),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_data          (out_data),
        .fifo_count        (fifo_count),
        .err_clr           (err_clr),
        .err_status        (err_status)
    );

    function automatic logic [EW-1:0] mk_entry(input logic [GW-1:0] ts, input logic flag,
                                               input logic [NQ-1:0] got, input logic [NQ-1:0] res);
        logic [GW+2*NQ:0] full_e;
        full_e = {ts, flag, got, res};
        return EW'(full_e);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted entry is compared with the oldest expectation
    initial forever begin
        @(negedge clk);
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_entry actual=%0h required=none", out_data);
            end else begin
                check("entry", 64'(out_data), 64'(exp_q.pop_front()));
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end

    // Round-level model: a strobe for an expected qubit counts if it arrives at offset
    // 1..timeout (any offset when timeout=0); the entry is flagged if any expected qubit is missing.
    task automatic run_round(input logic [NQ-1:0] mask, input logic [TW-1:0] tmo,
                             input int off[NQ], input logic [NQ-1:0] vals,
                             input logic [GW-1:0] ts, input bit wait_space, input bit chk_timing);
        logic [NQ-1:0] acc, strobe;
        int last_acc, last_any, end_k, total, n;
        acc = '0; last_acc = 0; last_any = 0;
        for (int i = 0; i < NQ; i++) begin
            if (off[i] > last_any) last_any = off[i];
            if (mask[i] && off[i] > 0 && (tmo == 0 || off[i] <= int'(tmo))) begin
                acc[i] = 1'b1;
                if (off[i] > last_acc) last_acc = off[i];
            end
        end
        end_k = (acc == mask) ? last_acc : int'(tmo);
        if (wait_space) begin
            n = 0;
            while (fifo_count > 14 && n < 1000) begin step(); n++; end
            check("space_wait", 64'(n < 1000), 64'd1);
        end
        exp_q.push_back(mk_entry(ts, acc != mask, acc, vals & acc));
        timeout_cycles = tmo;
        glb_counter    = ts;
        expect_mask    = mask;
        expect_valid   = 1'b1;
        step();
        expect_valid = 1'b0;
        expect_mask  = '0;
        glb_counter  = GW'($urandom);
        total = ((last_any > end_k) ? last_any : end_k) + 2;
        for (int k = 1; k <= total; k++) begin
            for (int i = 0; i < NQ; i++) strobe[i] = (off[i] == k);
            valid_meas_result = strobe;
            meas_result = (NQ'($urandom) & ~strobe) | (vals & strobe);
            if (chk_timing) check("out_valid_timing", 64'(out_valid), 64'(k >= end_k + 2));
            step();
        end
        valid_meas_result = '0;
        meas_result       = '0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while ((out_valid || fifo_count != 0) && n < 200) begin step(); n++; end
        check("drain_done", 64'(n < 200), 64'd1);
        out_ready = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
    endtask

    initial begin
        int off[NQ];
        logic [NQ-1:0] m;
        logic [TW-1:0] t;

        step(); step();
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_data", 64'(out_data), 64'd0);
        check("reset_fifo_count", 64'(fifo_count), 64'd0);
        check("reset_err", 64'(err_status), 64'd0);
        rst_n = 1'b1;
        step();

        // Zero-mask expect is ignored silently
        expect_valid = 1'b1; expect_mask = '0;
        step();
        expect_valid = 1'b0;
        step(); step();
        check("zero_mask_err", 64'(err_status), 64'd0);
        check("zero_mask_count", 64'(fifo_count), 64'd0);

        // Complete round: q0=1 at t+2, q2=0 at t+4
        for (int i = 0; i < NQ; i++) off[i] = 0;
        off[0] = 2; off[2] = 4;
        run_round(8'h05, 16'd0, off, 8'h01, 24'd100, 1'b0, 1'b1);
        drain();

        // Timeout: only q1 arrives
        for (int i = 0; i < NQ; i++) off[i] = 0;
        off[1] = 2;
        run_round(8'h03, 16'd4, off, 8'h02, 24'd200, 1'b0, 1'b1);
        drain();

        // Completion in the same cycle the timer expires
        for (int i = 0; i < NQ; i++) off[i] = 0;
        off[1] = 2; off[2] = 2;
        run_round(8'h06, 16'd2, off, 8'h04, 24'd300, 1'b0, 1'b1);
        drain();

        // Error sources
        valid_meas_result = 8'h08;
        step();
        valid_meas_result = '0;
        check("err_idle_strobe", 64'(err_status), 64'd1);
        exp_q.push_back(mk_entry(24'd400, 1'b0, 8'h03, 8'h01));
        timeout_cycles = '0; glb_counter = 24'd400; expect_mask = 8'h03; expect_valid = 1'b1;
        step();
        expect_valid = 1'b0;
        valid_meas_result = 8'h01; meas_result = 8'h01;
        step();
        valid_meas_result = 8'h01; meas_result = 8'h00; expect_valid = 1'b1; expect_mask = 8'hFF;
        step();
        expect_valid = 1'b0; expect_mask = '0;
        valid_meas_result = 8'h02; meas_result = 8'h00;
        step();
        valid_meas_result = '0;
        step(); step();
        check("err_all", 64'(err_status), 64'h7);
        pulse_clr();
        check("err_cleared", 64'(err_status), 64'd0);
        err_clr = 1'b1; valid_meas_result = 8'h01;
        step();
        err_clr = 1'b0; valid_meas_result = '0;
        check("err_set_beats_clr", 64'(err_status), 64'd1);
        pulse_clr();
        drain();

        // Backpressure: 17 rounds with the consumer stalled
        for (int i = 0; i < NQ; i++) off[i] = 0;
        off[0] = 1;
        for (int r = 0; r < 17; r++) begin
            run_round(8'h01, 16'd0, off, NQ'($urandom), GW'($urandom), 1'b0, 1'b0);
        end
        check("bp_count_full", 64'(fifo_count), 64'd16);
        check("bp_valid", 64'(out_valid), 64'd1);
        expect_valid = 1'b1; expect_mask = 8'h01;
        step();
        expect_valid = 1'b0; expect_mask = '0;
        check("bp_overlap_err", 64'(err_status), 64'd2);
        check("bp_count_held", 64'(fifo_count), 64'd16);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_pop_push_count", 64'(fifo_count), 64'd16);
        step();
        check("bp_count_after", 64'(fifo_count), 64'd16);
        pulse_clr();
        drain();

        // Reset in the middle of a round, with an entry already queued
        run_round(8'h01, 16'd0, off, 8'h01, 24'd500, 1'b0, 1'b0);
        timeout_cycles = '0; expect_mask = 8'h03; expect_valid = 1'b1;
        step();
        expect_valid = 1'b0; expect_mask = '0;
        valid_meas_result = 8'h01; meas_result = 8'h01;
        step();
        valid_meas_result = '0;
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_fifo_count", 64'(fifo_count), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_err", 64'(err_status), 64'd0);
        exp_q.delete();
        step();
        rst_n = 1'b1;
        step();
        for (int i = 0; i < NQ; i++) off[i] = 0;
        off[0] = 1; off[1] = 1;
        run_round(8'h03, 16'd0, off, 8'h02, 24'd600, 1'b0, 1'b1);
        drain();

        // Random rounds with a randomly stalling consumer
        rand_ready = 1'b1;
        for (int r = 0; r < 60; r++) begin
            m = NQ'($urandom_range(1, 255));
            t = ($urandom_range(0, 2) == 0) ? '0 : TW'($urandom_range(1, 8));
            for (int i = 0; i < NQ; i++) begin
                if (m[i]) off[i] = (t == 0) ? $urandom_range(1, 8) : $urandom_range(0, 10);
                else      off[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
            end
            run_round(m, t, off, NQ'($urandom), GW'($urandom), 1'b1, 1'b0);
        end
        rand_ready = 1'b0;
        step();
        pulse_clr();
        drain();

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
